// File: rtl/cube_net_renderer.sv
// cube_net_renderer: holds the 54 facelet colours and draws them as a 12x9-cell cross net centred on (CubeX, CubeY)
// Ports: Clk/Reset (async, active-low); DrawX/DrawY/draw_valid pixel request; CubeX/CubeY net centre;
// CubeS facelet border width; wr_valid/wr_index/wr_color/wr_ready facelet write port; init_req restores
// the solved state; Red/Green/Blue/pix_valid/pix_in_net pixel result, 3 cycles after the request.
// Optional: define NET_CURSOR_EN to add cursor_index; that facelet's border is drawn magenta.
module cube_net_renderer #(
  parameter int FACELET_PX = 16,
  parameter int PIPE_LAT   = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       draw_valid,
  input  logic [9:0] CubeX,
  input  logic [9:0] CubeY,
  input  logic [9:0] CubeS,
  input  logic       wr_valid,
  input  logic [5:0] wr_index,
  input  logic [2:0] wr_color,
  output logic       wr_ready,
  input  logic       init_req,
`ifdef NET_CURSOR_EN
  input  logic [5:0] cursor_index,
`endif
  output logic [7:0] Red,
  output logic [7:0] Green,
  output logic [7:0] Blue,
  output logic       pix_valid,
  output logic       pix_in_net
);
  localparam int LF = $clog2(FACELET_PX);
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;
  logic [0:0] state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [2:0] facelet_q [54];
  logic [2:0] facelet_d [54];
  logic [11:0] rx, ry;
  logic [LF+3:0] rx_q, rx_d, ry_q, ry_d;
  logic in_q, in_d;
  logic [9:0] cs_q, cs_d;
  logic [3:0] col, row, cm, rm;
  logic [1:0] cb, rb;
  logic [2:0] face, color;
  logic [5:0] idx_q, idx_d;
  logic fv_q, fv_d, bord_q, bord_d;
  logic [23:0] pal, bcol, rgb_q, rgb_d;
  logic in_net_q, in_net_d;
  logic [PIPE_LAT-1:0] vld_q, vld_d;
  assign wr_ready = state_q == ST_IDLE;
  assign {Red, Green, Blue} = rgb_q;
  assign pix_valid = vld_q[PIPE_LAT-1];
  assign pix_in_net = in_net_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    facelet_d = facelet_q;
    if (state_q == ST_INIT) begin
      facelet_d[cnt_q] = 3'(cnt_q / 6'd9);
      cnt_d = cnt_q == 6'd53 ? 6'd0 : cnt_q + 6'd1;
      state_d = cnt_q == 6'd53 ? ST_IDLE : ST_INIT;
    end else if (wr_valid && wr_index < 6'd54) begin
      facelet_d[wr_index] = wr_color;
    end
    if (init_req) begin
      state_d = ST_INIT;
      cnt_d = 6'd0;
    end
  end
  // Stage 1: offsets from the net origin. Unsigned wrap makes pixels left/above the origin compare as huge.
  always_comb begin
    rx = {2'b0, DrawX} - ({2'b0, CubeX} - 12'(6 * FACELET_PX));
    ry = {2'b0, DrawY} - ({2'b0, CubeY} - 12'((9 * FACELET_PX) / 2));
    in_d = rx < 12'(12 * FACELET_PX) && ry < 12'(9 * FACELET_PX);
    rx_d = rx[LF+3:0];
    ry_d = ry[LF+3:0];
    cs_d = CubeS;
  end
  // Stage 2: cell -> face band, facelet index and border test.
  always_comb begin
    col = rx_q[LF+3:LF];
    row = ry_q[LF+3:LF];
    cb = col < 4'd3 ? 2'd0 : col < 4'd6 ? 2'd1 : col < 4'd9 ? 2'd2 : 2'd3;
    rb = row < 4'd3 ? 2'd0 : row < 4'd6 ? 2'd1 : 2'd2;
    cm = col - 4'(cb) * 4'd3;
    rm = row - 4'(rb) * 4'd3;
    face = rb == 2'd0 ? 3'd0 : rb == 2'd2 ? 3'd5 : 3'(cb) + 3'd1;
    fv_d = in_q && (rb == 2'd1 || cb == 2'd1);
    idx_d = fv_d ? 6'(face) * 6'd9 + 6'(rm) * 6'd3 + 6'(cm) : 6'd0;
    bord_d = 10'(rx_q[LF-1:0]) < cs_q || 10'(ry_q[LF-1:0]) < cs_q;
  end
  // Stage 3: reads the registered array, so a write landing this cycle shows up one pixel later.
  always_comb begin
    color = facelet_q[idx_q];
    pal = color == 3'd0 ? 24'hFFFFFF : color == 3'd1 ? 24'hFF8000 : color == 3'd2 ? 24'h00C000 :
          color == 3'd3 ? 24'hFF0000 : color == 3'd4 ? 24'h0000FF : color == 3'd5 ? 24'hFFFF00 : 24'h808080;
`ifdef NET_CURSOR_EN
    bcol = idx_q == cursor_index ? 24'hFF00FF : 24'h000000;
`else
    bcol = 24'h000000;
`endif
    rgb_d = !fv_q ? 24'h404040 : bord_q ? bcol : pal;
    in_net_d = fv_q;
    vld_d = {vld_q[PIPE_LAT-2:0], draw_valid};
  end
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_INIT;
      cnt_q <= '0;
      facelet_q <= '{default: '0};
      rx_q <= '0;
      ry_q <= '0;
      in_q <= 1'b0;
      cs_q <= '0;
      idx_q <= '0;
      fv_q <= 1'b0;
      bord_q <= 1'b0;
      rgb_q <= '0;
      in_net_q <= 1'b0;
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      facelet_q <= facelet_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      in_q <= in_d;
      cs_q <= cs_d;
      idx_q <= idx_d;
      fv_q <= fv_d;
      bord_q <= bord_d;
      rgb_q <= rgb_d;
      in_net_q <= in_net_d;
      vld_q <= vld_d;
    end
  end
endmodule

// File: tb/tb_cube_net_renderer.sv
// tb_cube_net_renderer: directed checks of the cube net renderer with CubeX=320, CubeY=240, F=16 (origin 224,168)
module tb_cube_net_renderer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [9:0] draw_x = '0, draw_y = '0, cube_x = 10'd320, cube_y = 10'd240, cube_s = 10'd4;
  logic draw_valid = 1'b0, wr_valid = 1'b0, init_req = 1'b0;
  logic [5:0] wr_index = '0;
  logic [2:0] wr_color = '0;
`ifdef NET_CURSOR_EN
  logic [5:0] cursor_index = 6'd63;
`endif
  logic wr_ready, pix_valid, pix_in_net;
  logic [7:0] red, green, blue;
  logic [23:0] rgb;
  int vectors = 0;
  int miscompares = 0;
  assign rgb = {red, green, blue};
  always #5 clk = ~clk;
  cube_net_renderer dut (
    .Clk(clk), .Reset(rst_n), .DrawX(draw_x), .DrawY(draw_y), .draw_valid(draw_valid),
    .CubeX(cube_x), .CubeY(cube_y), .CubeS(cube_s), .wr_valid(wr_valid), .wr_index(wr_index),
    .wr_color(wr_color), .wr_ready(wr_ready), .init_req(init_req),
`ifdef NET_CURSOR_EN
    .cursor_index(cursor_index),
`endif
    .Red(red), .Green(green), .Blue(blue), .pix_valid(pix_valid), .pix_in_net(pix_in_net)
  );
  task automatic pixel(input logic [9:0] x, input logic [9:0] y);
    @(negedge clk);
    draw_x = x;
    draw_y = y;
    draw_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic write(input logic [5:0] i, input logic [2:0] c);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_index = i;
    wr_color = c;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (!wr_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic test_reset;
    int n;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL reset_wr_ready got %b want 0", wr_ready); end
    vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL reset_pix_valid got %b want 0", pix_valid); end
    vectors++; if (pix_in_net !== 1'b0) begin miscompares++; $display("FAIL reset_in_net got %b want 0", pix_in_net); end
    vectors++; if (rgb !== 24'h0) begin miscompares++; $display("FAIL reset_rgb got %h want 000000", rgb); end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    vectors++; if (n !== 54) begin miscompares++; $display("FAIL sweep_cycles got %0d want 54", n); end
  endtask
  task automatic test_solved;
    pixel(10'd280, 10'd176);
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL idx0_rgb got %h want FFFFFF", rgb); end
    vectors++; if (pix_in_net !== 1'b1) begin miscompares++; $display("FAIL idx0_in_net got %b want 1", pix_in_net); end
    vectors++; if (pix_valid !== 1'b1) begin miscompares++; $display("FAIL idx0_valid got %b want 1", pix_valid); end
    pixel(10'd232, 10'd224);
    vectors++; if (rgb !== 24'hFF8000) begin miscompares++; $display("FAIL idx9_rgb got %h want FF8000", rgb); end
    pixel(10'd312, 10'd304);
    vectors++; if (rgb !== 24'hFFFF00) begin miscompares++; $display("FAIL idx53_rgb got %h want FFFF00", rgb); end
    pixel(10'd132, 10'd168);
    vectors++; if (rgb !== 24'h404040) begin miscompares++; $display("FAIL outside_rgb got %h want 404040", rgb); end
    vectors++; if (pix_in_net !== 1'b0) begin miscompares++; $display("FAIL outside_in_net got %b want 0", pix_in_net); end
    pixel(10'd232, 10'd168);
    vectors++; if (rgb !== 24'h404040) begin miscompares++; $display("FAIL corner_rgb got %h want 404040", rgb); end
    vectors++; if (pix_in_net !== 1'b0) begin miscompares++; $display("FAIL corner_in_net got %b want 0", pix_in_net); end
    pixel(10'd272, 10'd168);
    vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL border_rgb got %h want 000000", rgb); end
    vectors++; if (pix_in_net !== 1'b1) begin miscompares++; $display("FAIL border_in_net got %b want 1", pix_in_net); end
  endtask
  task automatic test_collision;
    @(negedge clk);
    draw_x = 10'd296;
    draw_y = 10'd240;
    draw_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_index = 6'd22;
    wr_color = 3'd4;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    vectors++; if (rgb !== 24'h00C000) begin miscompares++; $display("FAIL collide_old got %h want 00C000", rgb); end
    @(posedge clk);
    #1;
    vectors++; if (rgb !== 24'h0000FF) begin miscompares++; $display("FAIL collide_new got %h want 0000FF", rgb); end
  endtask
  task automatic test_bad_index;
    write(6'd60, 3'd3);
    vectors++; if (wr_ready !== 1'b1) begin miscompares++; $display("FAIL bad_idx_ready got %b want 1", wr_ready); end
    pixel(10'd280, 10'd176);
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL bad_idx_0 got %h want FFFFFF", rgb); end
    pixel(10'd312, 10'd304);
    vectors++; if (rgb !== 24'hFFFF00) begin miscompares++; $display("FAIL bad_idx_53 got %h want FFFF00", rgb); end
  endtask
  task automatic test_init;
    int n;
    write(6'd0, 3'd3);
    pixel(10'd280, 10'd176);
    vectors++; if (rgb !== 24'hFF0000) begin miscompares++; $display("FAIL wr0_red got %h want FF0000", rgb); end
    write(6'd53, 3'd7);
    pixel(10'd312, 10'd304);
    vectors++; if (rgb !== 24'h808080) begin miscompares++; $display("FAIL wr53_grey got %h want 808080", rgb); end
    @(negedge clk);
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    vectors++; if (wr_ready !== 1'b0) begin miscompares++; $display("FAIL init_ready got %b want 0", wr_ready); end
    repeat (30) @(posedge clk);
    #1;
    init_req = 1'b1;
    @(posedge clk);
    #1;
    init_req = 1'b0;
    wait_ready(n);
    vectors++; if (n !== 54) begin miscompares++; $display("FAIL restart_cycles got %0d want 54", n); end
    pixel(10'd280, 10'd176);
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL init_idx0 got %h want FFFFFF", rgb); end
    pixel(10'd312, 10'd304);
    vectors++; if (rgb !== 24'hFFFF00) begin miscompares++; $display("FAIL init_idx53 got %h want FFFF00", rgb); end
    pixel(10'd296, 10'd240);
    vectors++; if (rgb !== 24'h00C000) begin miscompares++; $display("FAIL init_idx22 got %h want 00C000", rgb); end
  endtask
  task automatic test_border;
    cube_s = 10'd0;
    pixel(10'd272, 10'd168);
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL no_border got %h want FFFFFF", rgb); end
    cube_s = 10'd16;
    pixel(10'd280, 10'd176);
    vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL full_border got %h want 000000", rgb); end
    vectors++; if (pix_in_net !== 1'b1) begin miscompares++; $display("FAIL full_border_in_net got %b want 1", pix_in_net); end
    cube_s = 10'd15;
    pixel(10'd287, 10'd183);
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL border15_edge got %h want FFFFFF", rgb); end
    pixel(10'd286, 10'd183);
    vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL border15_in got %h want 000000", rgb); end
    cube_s = 10'd4;
  endtask
  task automatic test_back_to_back;
    @(negedge clk);
    draw_x = 10'd280; draw_y = 10'd176; draw_valid = 1'b1;
    @(negedge clk);
    draw_x = 10'd232; draw_y = 10'd224;
    @(negedge clk);
    draw_x = 10'd132; draw_y = 10'd168;
    @(posedge clk);
    #1;
    vectors++; if (rgb !== 24'hFFFFFF) begin miscompares++; $display("FAIL b2b_0 got %h want FFFFFF", rgb); end
    @(negedge clk);
    draw_valid = 1'b0;
    @(posedge clk);
    #1;
    vectors++; if (rgb !== 24'hFF8000) begin miscompares++; $display("FAIL b2b_1 got %h want FF8000", rgb); end
    @(posedge clk);
    #1;
    vectors++; if (rgb !== 24'h404040) begin miscompares++; $display("FAIL b2b_2 got %h want 404040", rgb); end
    vectors++; if (pix_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_2_valid got %b want 1", pix_valid); end
    @(posedge clk);
    #1;
    vectors++; if (pix_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_bubble got %b want 0", pix_valid); end
  endtask
`ifdef NET_CURSOR_EN
  task automatic test_cursor;
    cursor_index = 6'd0;
    pixel(10'd272, 10'd168);
    vectors++; if (rgb !== 24'hFF00FF) begin miscompares++; $display("FAIL cursor_border got %h want FF00FF", rgb); end
    pixel(10'd272, 10'd216);
    vectors++; if (rgb !== 24'h000000) begin miscompares++; $display("FAIL noncursor_border got %h want 000000", rgb); end
    cursor_index = 6'd63;
  endtask
`endif
  initial begin
    test_reset;
    test_solved;
    test_collision;
    test_bad_index;
    test_init;
    test_border;
    test_back_to_back;
`ifdef NET_CURSOR_EN
    test_cursor;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
